// File: rtl/memory_responder.sv
// Fixed-latency single-port memory responder.
// Requests are accepted as levels and re-armed only after both inputs return low.
module memory_responder #(
    parameter int S       = 32,
    parameter int L       = 256,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  memory_addr,
    input  logic         memory_rden,
    input  logic         memory_wren,
    input  logic [S-1:0] memory_write_val,
    output logic [S-1:0] memory_read_val,
    output logic         memory_response,
    output logic         busy
);
    localparam int AW = $clog2(L);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [S-1:0]  wval_q, wval_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [S-1:0]  rval_q, rval_d;
    logic          resp_q, resp_d;
    logic          mem_we;
    logic [S-1:0]  mem_q [L];
    logic          addr_unused;

    // Upper address bits only select an alias of the same word.
    if (AW < 32) begin : g_addr_unused
        assign addr_unused = ^memory_addr[31:AW];
    end else begin : g_addr_full
        assign addr_unused = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wval_d  = wval_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rval_d  = rval_q;
        resp_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!memory_rden && !memory_wren) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    idx_d   = memory_addr[AW-1:0];
                    wval_d  = memory_write_val;
                    rd_d    = memory_rden;
                    wr_d    = memory_wren;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    mem_we  = wr_q;
                    // Array read sees the pre-write word on the same edge.
                    if (rd_q) begin
                        rval_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wval_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rval_q  <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wval_q  <= wval_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rval_q  <= rval_d;
            resp_q  <= resp_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wval_q;
        end
    end

    assign memory_read_val = rval_q;
    assign memory_response = resp_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder against a word-array reference model.
// Each transaction is tracked edge by edge from its acceptance edge.
module tb_memory_responder;
    localparam int S   = 32;
    localparam int L   = 256;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  memory_addr;
    logic         memory_rden;
    logic         memory_wren;
    logic [S-1:0] memory_write_val;
    logic [S-1:0] memory_read_val;
    logic         memory_response;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [S-1:0] ref_mem [L];
    logic [S-1:0] ref_rd;

    memory_responder #(
        .S(S),
        .L(L),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memory_addr(memory_addr),
        .memory_rden(memory_rden),
        .memory_wren(memory_wren),
        .memory_write_val(memory_write_val),
        .memory_read_val(memory_read_val),
        .memory_response(memory_response),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) ref_mem[i] = '0;
        ref_rd = '0;
    endtask

    task automatic settle();
        memory_rden = 1'b0;
        memory_wren = 1'b0;
        @(negedge clk);
    endtask

    // Caller guarantees the block is idle and armed; acceptance is the next edge.
    task automatic xact(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [S-1:0] data, input bit hold,
                        input bit perturb);
        int           idx;
        logic [S-1:0] exp_rd;
        idx    = int'(addr % L);
        exp_rd = rd ? ref_mem[idx] : ref_rd;
        if (wr) ref_mem[idx] = data;
        ref_rd = exp_rd;
        memory_addr      = addr;
        memory_rden      = rd;
        memory_wren      = wr;
        memory_write_val = data;
        for (int k = 0; k <= LAT + 2; k++) begin
            @(negedge clk);
            check("resp", 64'(memory_response), 64'(k == LAT));
            if (k == 0) check("busy_wait", 64'(busy), 64'd1);
            if (k == LAT) check("rdata", 64'(memory_read_val), 64'(exp_rd));
            if (k == LAT + 2) begin
                check("busy_idle", 64'(busy), 64'd0);
                check("rdata_hold", 64'(memory_read_val), 64'(exp_rd));
            end
            if (k == 0 && !hold) begin
                memory_rden = 1'b0;
                memory_wren = 1'b0;
            end
            if (perturb && k < LAT) begin
                memory_addr      = $urandom;
                memory_write_val = $urandom;
            end
        end
        if (hold) begin
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                check("held_quiet", 64'({busy, memory_response}), 64'd0);
            end
        end
        settle();
    endtask

    initial begin
        model_reset();
        reset            = 1'b1;
        memory_addr      = '0;
        memory_rden      = 1'b1;
        memory_wren      = 1'b0;
        memory_write_val = '0;
        repeat (2) @(negedge clk);
        check("rst_resp", 64'(memory_response), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata", 64'(memory_read_val), 64'd0);

        // Request held across reset release must not be taken until re-armed.
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("unarmed_busy", 64'(busy), 64'd0);
        settle();

        xact(32'd5, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        xact(32'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("raw_val", 64'(memory_read_val), 64'hDEADBEEF);

        xact(32'h105, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0);
        xact(32'h005, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_val", 64'(memory_read_val), 64'h12345678);

        xact(32'd7, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
        xact(32'd7, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
        check("rbw_old", 64'(memory_read_val), 64'h1);
        xact(32'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rbw_new", 64'(memory_read_val), 64'h2);

        xact(32'd9, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        xact(32'd11, 1'b0, 1'b1, 32'hCAFE0011, 1'b1, 1'b1);
        xact(32'd11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("capt_val", 64'(memory_read_val), 64'hCAFE0011);

        // Abort a write in WAIT.
        memory_addr      = 32'd3;
        memory_write_val = 32'hAA;
        memory_wren      = 1'b1;
        @(negedge clk);
        memory_wren = 1'b0;
        @(negedge clk);
        check("pre_abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            check("abort_quiet", 64'({busy, memory_response}), 64'd0);
        end
        check("abort_rdata", 64'(memory_read_val), 64'd0);
        xact(32'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("abort_nowrite", 64'(memory_read_val), 64'd0);

        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            int          op;
            a  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            op = $urandom_range(1, 3);
            xact(a, op[0], op[1], $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
